// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets and elaboration-time helpers for the raster
// timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_display;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_display;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h_display: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_display: 480, v_front: 10, v_sync: 2,  v_back: 33
    };

    localparam vga_mode_t SVGA_800x600 = '{
        h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_display: 600, v_front: 1,  v_sync: 4,   v_back: 23
    };

    // Ceiling log2, never below 1 so a counter of one state still gets a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel clock enable: one tick every CLK_DIV system clocks while enabled;
// the divider phase is held when enable drops.
module pixel_tick_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned   DW       = clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;
    logic          at_last;

    assign at_last = (div_cnt_q == DIV_LAST);
    assign tick_o  = enable_i && at_last;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (enable_i) begin
            div_cnt_d = at_last ? '0 : div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Every output is registered one
// clock behind the h/v counters, so all outputs stay mutually aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_640x480.h_display,
    parameter int unsigned H_FRONT   = VGA_640x480.h_front,
    parameter int unsigned H_SYNC    = VGA_640x480.h_sync,
    parameter int unsigned H_BACK    = VGA_640x480.h_back,
    parameter int unsigned V_DISPLAY = VGA_640x480.v_display,
    parameter int unsigned V_FRONT   = VGA_640x480.v_front,
    parameter int unsigned V_SYNC    = VGA_640x480.v_sync,
    parameter int unsigned V_BACK    = VGA_640x480.v_back,
    parameter int unsigned CLK_DIV   = 2,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned FC_W      = 16,
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned CW       = clog2(H_TOTAL),
    localparam int unsigned CW_V     = clog2(V_TOTAL)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            video_on_o,
    output logic            p_tick_o,
    output logic [CW-1:0]   pixel_x_o,
    output logic [CW_V-1:0] pixel_y_o,
    output logic            line_end_o,
    output logic            frame_end_o,
    output logic [FC_W-1:0] frame_count_o
);

    if (CLK_DIV < 1 || H_DISPLAY == 0 || H_SYNC == 0 ||
        V_DISPLAY == 0 || V_SYNC == 0) begin : g_param_check
        $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1 and DISPLAY/SYNC fields non-zero");
    end

    localparam logic [CW-1:0]   H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]   H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0]   HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0]   HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW_V-1:0] V_LAST   = CW_V'(V_TOTAL - 1);
    localparam logic [CW_V-1:0] V_VIS    = CW_V'(V_DISPLAY);
    localparam logic [CW_V-1:0] VS_FIRST = CW_V'(V_DISPLAY + V_FRONT);
    localparam logic [CW_V-1:0] VS_LAST  = CW_V'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic            tick;
    logic            h_end;
    logic            v_end;

    logic [CW-1:0]   h_cnt_q,       h_cnt_d;
    logic [CW_V-1:0] v_cnt_q,       v_cnt_d;
    logic [CW-1:0]   pixel_x_q,     pixel_x_d;
    logic [CW_V-1:0] pixel_y_q,     pixel_y_d;
    logic            hsync_q,       hsync_d;
    logic            vsync_q,       vsync_d;
    logic            video_on_q,    video_on_d;
    logic            p_tick_q,      p_tick_d;
    logic            line_end_q,    line_end_d;
    logic            frame_end_q,   frame_end_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    assign h_end = (h_cnt_q == H_LAST);
    assign v_end = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_end ? '0 : h_cnt_q + CW'(1);
            if (h_end) begin
                v_cnt_d = v_end ? '0 : v_cnt_q + CW_V'(1);
            end
        end

        // Outputs sample the counters as they stand before this edge.
        pixel_x_d     = h_cnt_q;
        pixel_y_d     = v_cnt_q;
        video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_d       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        p_tick_d      = tick;
        line_end_d    = tick && h_end;
        frame_end_d   = tick && h_end && v_end;
        frame_count_d = frame_end_q ? frame_count_q + FC_W'(1) : frame_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            p_tick_q      <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            p_tick_q      <= p_tick_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_on_o    = video_on_q;
    assign p_tick_o      = p_tick_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign line_end_o    = line_end_q;
    assign frame_end_o   = frame_end_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny 7x6
// raster at CLK_DIV=1, and the same tiny raster at CLK_DIV=3 with high syncs.
module tb_vga_timing_gen;

    logic clk;
    int   n_tests;
    int   n_fail;

    logic rst_d, en_d, hs_d, vs_d, von_d, pt_d, le_d, fe_d;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic [15:0] fc_d;

    logic rst_s, en_s, hs_s, vs_s, von_s, pt_s, le_s, fe_s;
    logic [2:0] x_s;
    logic [2:0] y_s;
    logic [1:0] fc_s;

    logic rst_p, en_p, hs_p, vs_p, von_p, pt_p, le_p, fe_p;
    logic [2:0] x_p;
    logic [2:0] y_p;
    logic [1:0] fc_p;

    vga_timing_gen dut_d (
        .clk_i(clk), .reset_i(rst_d), .enable_i(en_d),
        .hsync_o(hs_d), .vsync_o(vs_d), .video_on_o(von_d), .p_tick_o(pt_d),
        .pixel_x_o(x_d), .pixel_y_o(y_d), .line_end_o(le_d),
        .frame_end_o(fe_d), .frame_count_o(fc_d)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .FC_W(2)
    ) dut_s (
        .clk_i(clk), .reset_i(rst_s), .enable_i(en_s),
        .hsync_o(hs_s), .vsync_o(vs_s), .video_on_o(von_s), .p_tick_o(pt_s),
        .pixel_x_o(x_s), .pixel_y_o(y_s), .line_end_o(le_s),
        .frame_end_o(fe_s), .frame_count_o(fc_s)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(3), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FC_W(2)
    ) dut_p (
        .clk_i(clk), .reset_i(rst_p), .enable_i(en_p),
        .hsync_o(hs_p), .vsync_o(vs_p), .video_on_o(von_p), .p_tick_o(pt_p),
        .pixel_x_o(x_p), .pixel_y_o(y_p), .line_end_o(le_p),
        .frame_end_o(fe_p), .frame_count_o(fc_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int pt_cnt, hs_cnt, hs_first_x, hs_last_x, von_fall_x;
    int le_cnt, le_k1, le_k2, le_x, le_pt, fe_cnt, x_1601, y_1600, y_1601;
    int found, bad, vs_cnt, fe_first, fe_last, fe_prev_k, int_bad, fc_idx;
    logic fe_seen;
    logic [1:0] fc_seq [5];
    logic [1:0] fc_exp [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_d = 1'b1; rst_s = 1'b1; rst_p = 1'b1;
        en_d  = 1'b1; en_s  = 1'b1; en_p  = 1'b1;

        repeat (3) step();
        check("rst_x",     x_d, 0);
        check("rst_y",     y_d, 0);
        check("rst_von",   von_d, 0);
        check("rst_pt",    pt_d, 0);
        check("rst_le",    le_d, 0);
        check("rst_fe",    fe_d, 0);
        check("rst_hs",    hs_d, 1);
        check("rst_vs",    vs_d, 1);
        check("rst_fc",    fc_d, 0);
        check("rst_s_hs",  hs_s, 1);
        check("rst_p_hs",  hs_p, 0);
        check("rst_p_vs",  vs_p, 0);

        // Default timing: two full lines plus one clock.
        rst_d = 1'b0;
        pt_cnt = 0; hs_cnt = 0; hs_first_x = -1; hs_last_x = -1; von_fall_x = -1;
        le_cnt = 0; le_k1 = -1; le_k2 = -1; le_x = -1; le_pt = -1; fe_cnt = 0;
        x_1601 = -1; y_1600 = -1; y_1601 = -1;
        for (int k = 1; k <= 3201; k++) begin
            step();
            if (k == 1) begin
                check("first_x",   x_d, 0);
                check("first_y",   y_d, 0);
                check("first_von", von_d, 1);
                check("first_pt",  pt_d, 0);
            end
            if (k <= 1600) begin
                if (pt_d) pt_cnt++;
                if (!hs_d) begin
                    hs_cnt++;
                    if (hs_first_x < 0) hs_first_x = int'(x_d);
                    hs_last_x = int'(x_d);
                end
                if (!von_d && von_fall_x < 0) von_fall_x = int'(x_d);
            end
            if (le_d) begin
                le_cnt++;
                if (le_k1 < 0) begin
                    le_k1 = k;
                    le_x  = int'(x_d);
                    le_pt = int'(pt_d);
                end else begin
                    le_k2 = k;
                end
            end
            if (fe_d) fe_cnt++;
            if (k == 1600) y_1600 = int'(y_d);
            if (k == 1601) begin
                x_1601 = int'(x_d);
                y_1601 = int'(y_d);
            end
        end
        check("line_pt_cnt",   pt_cnt, 800);
        check("line_hs_cnt",   hs_cnt, 192);
        check("line_hs_first", hs_first_x, 656);
        check("line_hs_last",  hs_last_x, 751);
        check("line_von_fall", von_fall_x, 640);
        check("line_le_cnt",   le_cnt, 2);
        check("line_le_clk",   le_k1, 1600);
        check("line_le_x",     le_x, 799);
        check("line_le_pt",    le_pt, 1);
        check("line_len",      le_k2 - le_k1, 1600);
        check("line_y_before", y_1600, 0);
        check("line_wrap_x",   x_1601, 0);
        check("line_wrap_y",   y_1601, 1);
        check("line_no_fe",    fe_cnt, 0);

        // Stall on the first clock of pixel 100.
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            step();
            if (x_d == 10'd100 && !pt_d) found = 1;
        end
        check("stall_reach", found, 1);
        en_d = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (x_d != 10'd100 || y_d != 10'd2 || pt_d || le_d || !von_d || !hs_d) bad++;
        end
        check("stall_frozen", bad, 0);
        en_d = 1'b1;
        step();
        check("resume_x0",  x_d, 100);
        check("resume_pt0", pt_d, 1);
        step();
        check("resume_x1",  x_d, 101);
        check("resume_pt1", pt_d, 0);

        // Reset in the middle of a line.
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            step();
            if (x_d == 10'd300) found = 1;
        end
        check("midrst_reach", found, 1);
        rst_d = 1'b1;
        step();
        check("midrst_x",   x_d, 0);
        check("midrst_y",   y_d, 0);
        check("midrst_von", von_d, 0);
        check("midrst_pt",  pt_d, 0);
        check("midrst_le",  le_d, 0);
        check("midrst_hs",  hs_d, 1);
        check("midrst_fc",  fc_d, 0);
        rst_d = 1'b0;
        step();
        check("midrst_rel_von", von_d, 1);
        check("midrst_rel_x",   x_d, 0);

        // Tiny raster, CLK_DIV=1: five frames of 42 clocks.
        fc_exp[0] = 2'd1; fc_exp[1] = 2'd2; fc_exp[2] = 2'd3; fc_exp[3] = 2'd0; fc_exp[4] = 2'd1;
        for (int i = 0; i < 5; i++) fc_seq[i] = 2'bxx;
        rst_s = 1'b0;
        hs_cnt = 0; vs_cnt = 0; le_cnt = 0; fe_cnt = 0; bad = 0;
        fe_first = -1; fe_last = -1; fe_prev_k = -1; int_bad = 0; fc_idx = 0;
        fe_seen = 1'b0;
        for (int k = 1; k <= 211; k++) begin
            step();
            if (k == 1) begin
                check("s_first_x",  x_s, 0);
                check("s_first_pt", pt_s, 1);
                check("s_first_von", von_s, 1);
            end
            if (fe_seen && fc_idx < 5) begin
                fc_seq[fc_idx] = fc_s;
                fc_idx++;
                if (x_s != 3'd0 || y_s != 3'd0) bad++;
            end
            fe_seen = fe_s;
            if (fe_s) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = k;
                if (fe_prev_k >= 0 && k - fe_prev_k != 42) int_bad++;
                fe_prev_k = k;
                fe_last = k;
            end
            if (k <= 210) begin
                if (!hs_s) hs_cnt++;
                if (!vs_s) vs_cnt++;
                if (le_s) le_cnt++;
                if ((!hs_s && x_s != 3'd5) || (!vs_s && y_s != 3'd4)) bad++;
            end
        end
        check("s_fe_cnt",   fe_cnt, 5);
        check("s_fe_first", fe_first, 42);
        check("s_fe_last",  fe_last, 210);
        check("s_fe_intvl", int_bad, 0);
        check("s_hs_cnt",   hs_cnt, 30);
        check("s_vs_cnt",   vs_cnt, 35);
        check("s_le_cnt",   le_cnt, 30);
        check("s_win_bad",  bad, 0);
        for (int i = 0; i < 5; i++) check($sformatf("s_fc_seq%0d", i), fc_seq[i], fc_exp[i]);

        repeat (10) step();
        check("s_pre_rst_fc", fc_s, 1);
        rst_s = 1'b1;
        step();
        check("s_rst_fc",  fc_s, 0);
        check("s_rst_x",   x_s, 0);
        check("s_rst_y",   y_s, 0);
        check("s_rst_pt",  pt_s, 0);
        check("s_rst_le",  le_s, 0);
        check("s_rst_fe",  fe_s, 0);
        check("s_rst_hs",  hs_s, 1);
        check("s_rst_vs",  vs_s, 1);

        // Tiny raster, CLK_DIV=3, active-high syncs: one frame of 126 clocks.
        rst_p = 1'b0;
        pt_cnt = 0; hs_cnt = 0; vs_cnt = 0; fe_cnt = 0; fe_first = -1; bad = 0;
        for (int k = 1; k <= 127; k++) begin
            step();
            if (k == 1) check("p_first_pt", pt_p, 0);
            if (k == 3) check("p_third_pt", pt_p, 1);
            if (k <= 126) begin
                if (pt_p) pt_cnt++;
                if (hs_p) hs_cnt++;
                if (vs_p) vs_cnt++;
                if ((hs_p && x_p != 3'd5) || (vs_p && y_p != 3'd4)) bad++;
                if (fe_p) begin
                    fe_cnt++;
                    if (fe_first < 0) fe_first = k;
                end
            end
            if (k == 127) begin
                check("p_wrap_x",  x_p, 0);
                check("p_wrap_y",  y_p, 0);
                check("p_wrap_fc", fc_p, 1);
            end
        end
        check("p_pt_cnt",   pt_cnt, 42);
        check("p_hs_cnt",   hs_cnt, 18);
        check("p_vs_cnt",   vs_cnt, 21);
        check("p_win_bad",  bad, 0);
        check("p_fe_cnt",   fe_cnt, 1);
        check("p_fe_clk",   fe_first, 126);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480 sync block. It has the following generalisations:
- Every horizontal and vertical timing field is a parameter.
- The pixel clock divider ratio and the sync polarity are parameters.
- It adds a run/stall enable, line-end and frame-end strobes, and a frame counter.

All outputs are mutually aligned. It sits between the system clock and the pixel generators and game renderers.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, h. front porch (after display, before sync)
H_SYNC, 96, h. sync pulse width
H_BACK, 48, h. back porch
V_DISPLAY, 480, visible lines
V_FRONT, 10, v. front porch
V_SYNC, 2, v. sync width
V_BACK, 33, v. back porch
CLK_DIV, 2, clk cycles per pixel (>=1)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
FC_W, 16, frame_count width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = timing advances; 0 = freeze raster position
hsync  out  1  horizontal sync, level per HSYNC_POL
vsync  out  1  vertical sync, level per VSYNC_POL
video_on  out  1  pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
p_tick  out  1  last clk of the current pixel on the outputs
pixel_x  out  CW  current column; CW = clog2(H_TOTAL), derived
pixel_y  out  CW_V  current row; CW_V = clog2(V_TOTAL), derived
line_end  out  1  p_tick and pixel_x == H_TOTAL-1
frame_end  out  1  line_end and pixel_y == V_TOTAL-1
frame_count  out  FC_W  completed frames since reset, wraps

Behaviour:
- Derived localparams: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Elaboration must fail if CLK_DIV < 1 or any DISPLAY or SYNC field is 0.
- Divider div_cnt runs 0..CLK_DIV-1 while enable=1.
  - tick = enable && div_cnt == CLK_DIV-1.
  - With CLK_DIV=1, tick = enable.
- h_cnt advances on tick and wraps H_TOTAL-1 -> 0.
- v_cnt advances on tick && h_cnt == H_TOTAL-1, and wraps V_TOTAL-1 -> 0.
- Output stage: every output is a register loaded each clk from the current counter/tick values. All outputs are therefore exactly 1 clk behind the counters and glitch-free.
  - p_tick reg <= tick; line_end reg <= tick && h_end; frame_end reg <= tick && h_end && v_end.
  - hsync active when h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], otherwise inactive. vsync uses the same rule on v_cnt.
  - frame_count <= frame_count+1 in the clk where frame_end output = 1. It therefore changes at the same edge the outputs move to (0,0), and wraps at 2^FC_W.
- Reset (sync, highest priority):
  - div_cnt=h_cnt=v_cnt=0, frame_count=0.
  - pixel_x=pixel_y=0, video_on=0, p_tick=line_end=frame_end=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- After reset: first clk after reset deasserts, outputs show (0,0) with video_on=1.
- Reset mid-frame: same as above; no partial strobes are emitted.
- enable=0:
  - div_cnt, h_cnt and v_cnt hold; tick=0.
  - The output registers keep reloading identical values; p_tick, line_end and frame_end read 0.
  - Resume continues from the held div_cnt, with no skipped or repeated pixel.
- Pixel duration is exactly CLK_DIV clks when enable stays 1. Line = H_TOTAL*CLK_DIV clks. Frame = V_TOTAL*H_TOTAL*CLK_DIV clks.

Decomposition:
- Package vga_timing_pkg: preset constant sets VGA_640x480 (defaults above) and SVGA_800x600 (800/40/128/88, 600/1/4/23), plus a clog2 helper.
- One sub-module pixel_tick_div (CLK_DIV, enable -> tick) is natural.
- h/v counters and the output stage stay in the top.

Test Plan:
- Reset held 3 clks, defaults -> all outputs at reset values; hsync=vsync=1. First post-reset clk shows pixel_x=0, pixel_y=0, video_on=1.
- Defaults, run one line -> p_tick every 2nd clk. hsync=0 exactly for pixel_x 656..751 (192 clks). video_on falls at pixel_x=640. line_end one clk at pixel_x=799; pixel_x then 0, pixel_y 0->1. Line length 1600 clks.
- Defaults, run full frame -> vsync=0 only for pixel_y 490..491. frame_end once per 840000 clks. frame_count 0->1 as outputs return to (0,0).
- Small config H=4/1/1/1, V=3/1/1/1, CLK_DIV=1, FC_W=2, run 5 frames -> frame_end every 42 clks. frame_count sequence 1,2,3,0,1. hsync active at x=5 only.
- HSYNC_POL=1, VSYNC_POL=1 -> syncs idle 0 after reset, pulse high in the same windows.
- Defaults, drop enable for 10 clks at pixel_x=100 mid-pixel -> outputs frozen, p_tick=0. After resume, pixel 100 lasts its remaining clks, total pixel clks = 2.
- Assert reset at pixel (300,200) -> next clk all outputs at reset values; frame_count=0.
